// File: rtl/lp805x_schedfs_pkg.sv
// Shared constants and FSM encoding for the lp805x frequency-scaling scheduler.
package lp805x_schedfs_pkg;
  localparam int FW    = 9;
  localparam int IW    = 3;
  localparam int P_MSB = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;
endpackage

// File: rtl/lp805x_schedfs_if.sv
// Request/result bundle between the clock-select controller and the scheduler core.
interface lp805x_schedfs_if #(
  parameter int FW = lp805x_schedfs_pkg::FW,
  parameter int IW = lp805x_schedfs_pkg::IW
) ();
  logic          enable;
  logic          start;
  logic [FW-1:0] factor;
  logic [IW-1:0] index;

  modport master (output enable, output start, output factor, input  index);
  modport slave  (input  enable, input  start, input  factor, output index);
endinterface

// File: rtl/lp805x_schedfs_core.sv
// Scans a latched scaling factor MSB-first, one bit per enabled clock, and
// publishes the divider tap (floor(log2(factor)) - 1, or 0 for factor < 2).
module lp805x_schedfs_core #(
  parameter int FW = lp805x_schedfs_pkg::FW,
  parameter int IW = lp805x_schedfs_pkg::IW
) (
  input  logic              clk,
  input  logic              rst,
  lp805x_schedfs_if.slave   bus
);
  import lp805x_schedfs_pkg::*;

  localparam int PW = $clog2(FW);

  state_t        r_state;
  logic [PW-1:0] r_ptr;
  logic [FW-1:0] r_fact;
  logic [IW-1:0] r_index;

  state_t        w_state_nxt;
  logic [PW-1:0] w_ptr_nxt;
  logic [FW-1:0] w_fact_nxt;
  logic [IW-1:0] w_index_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_fact_nxt  = r_fact;
    w_index_nxt = r_index;
    // A start pulse always wins, so a scan in flight is discarded and restarted.
    if (bus.start) begin
      w_fact_nxt  = bus.factor;
      w_ptr_nxt   = PW'(P_MSB);
      w_state_nxt = ST_SCAN;
    end else if (r_state == ST_SCAN) begin
      if (r_fact[r_ptr]) begin
        w_index_nxt = IW'(r_ptr - 1'b1);
        w_state_nxt = ST_IDLE;
      end else if (r_ptr == PW'(1)) begin
        w_index_nxt = '0;
        w_state_nxt = ST_IDLE;
      end else begin
        w_ptr_nxt = r_ptr - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= PW'(P_MSB);
      r_fact  <= '0;
      r_index <= '0;
    end else if (bus.enable) begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_fact  <= w_fact_nxt;
      r_index <= w_index_nxt;
    end
  end

  assign bus.index = r_index;
endmodule

// File: tb/tb_lp805x_schedfs_core.sv
// Directed bench for lp805x_schedfs_core: table of factors plus restart, hold,
// enable-gating and mid-scan reset sequences.
module tb_lp805x_schedfs_core;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  logic [2:0] prev;

  lp805x_schedfs_if #(.FW(9), .IW(3)) bus ();

  lp805x_schedfs_core #(.FW(9), .IW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] f;
    logic [2:0] idx;
    int         lat;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: index=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a posedge; the start edge is the following posedge.
  task automatic start_edge(input logic [8:0] f);
    bus.start  = 1'b1;
    bus.factor = f;
    @(posedge clk); #1;
    bus.start  = 1'b0;
  endtask

  task automatic run_scan(input string name, input logic [8:0] f,
                          input logic [2:0] exp, input int lat);
    start_edge(f);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      check(name, bus.index, (k < lat) ? prev : exp);
    end
    prev = exp;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; prev = 3'd0;
    tbl[0]  = '{9'd5,   3'd1, 7};
    tbl[1]  = '{9'd8,   3'd2, 6};
    tbl[2]  = '{9'd15,  3'd2, 6};
    tbl[3]  = '{9'd30,  3'd3, 5};
    tbl[4]  = '{9'd32,  3'd4, 4};
    tbl[5]  = '{9'd70,  3'd5, 3};
    tbl[6]  = '{9'd250, 3'd6, 2};
    tbl[7]  = '{9'd271, 3'd7, 1};
    tbl[8]  = '{9'd501, 3'd7, 1};
    tbl[9]  = '{9'd4,   3'd1, 7};
    tbl[10] = '{9'd0,   3'd0, 8};
    tbl[11] = '{9'd511, 3'd7, 1};
    tbl[12] = '{9'd1,   3'd0, 8};
    tbl[13] = '{9'd256, 3'd7, 1};
    tbl[14] = '{9'd3,   3'd0, 8};
    tbl[15] = '{9'd2,   3'd0, 8};

    rst = 1'b1;
    bus.enable = 1'b1;
    bus.start  = 1'b0;
    bus.factor = '0;
    repeat (10) @(posedge clk);
    #1;
    check("reset", bus.index, 3'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      run_scan($sformatf("factor_%0d", tbl[i].f), tbl[i].f, tbl[i].idx, tbl[i].lat);
    end

    // Restart: factor 5 abandoned after 2 cycles, factor 300 must win with no transient 1.
    run_scan("pre_restart", 9'd32, 3'd4, 4);
    start_edge(9'd5);
    repeat (2) begin
      @(posedge clk); #1;
      check("restart_hold", bus.index, 3'd4);
    end
    bus.start  = 1'b1;
    bus.factor = 9'd300;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    check("restart_edge", bus.index, 3'd4);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      check("restart_result", bus.index, 3'd7);
    end
    prev = 3'd7;

    // Held start retriggers; result only after start falls.
    bus.start  = 1'b1;
    bus.factor = 9'd30;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check("held_start", bus.index, 3'd7);
    end
    bus.start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      check("held_result", bus.index, (k < 5) ? 3'd7 : 3'd3);
    end
    prev = 3'd3;

    // Factor changes after the start edge are ignored.
    start_edge(9'd4);
    bus.factor = 9'd511;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      check("factor_ignored", bus.index, (k < 7) ? 3'd3 : 3'd1);
    end
    prev = 3'd1;

    // Enable gating: factor 2 needs 8 enabled edges regardless of a 5-cycle stall.
    start_edge(9'd2);
    repeat (3) begin
      @(posedge clk); #1;
      check("gate_pre", bus.index, 3'd1);
    end
    bus.enable = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("gate_frozen", bus.index, 3'd1);
    end
    bus.enable = 1'b1;
    for (int k = 4; k <= 10; k++) begin
      @(posedge clk); #1;
      check("gate_post", bus.index, (k < 8) ? 3'd1 : 3'd0);
    end
    prev = 3'd0;

    // Asynchronous reset in the middle of a scan of 501.
    run_scan("pre_reset", 9'd250, 3'd6, 2);
    start_edge(9'd501);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", bus.index, 3'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("post_reset_idle", bus.index, 3'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
